// File: rtl/lc3_ir_decode.sv
// -----------------------------------------------------------------------------
// lc3_ir_decode
// Instruction-register / decode stage for an LC-3 core. Accepts one 16-bit
// instruction per valid/ready handshake, splits it into register fields and
// condition codes, selects the opcode's immediate field, and sign- or
// zero-extends it to 16 bits. The decoded entry is held in a single registered
// pipeline slot for the execute stage.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of the held entry; also drops this cycle's input
//   in_valid     in_instr is valid this cycle
//   in_ready     stage can accept an instruction this cycle (combinational)
//   in_instr     raw instruction word
//   out_valid    decoded entry held
//   out_ready    downstream consumes the entry this cycle
//   out_opcode   instr[15:12]
//   out_dr       instr[11:9]  (DR, or SR for stores)
//   out_sr1      instr[8:6]   (SR1 / BaseR)
//   out_sr2      instr[2:0]
//   out_nzp      instr[11:9] for BR, otherwise 0
//   out_use_imm  ADD/AND in immediate mode
//   out_offset   extended immediate for the opcode
//   out_illegal  RTI (1000) or reserved (1101) opcode
// -----------------------------------------------------------------------------
module lc3_ir_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_dr,
    output logic [2:0]  out_sr1,
    output logic [2:0]  out_sr2,
    output logic [2:0]  out_nzp,
    output logic        out_use_imm,
    output logic [15:0] out_offset,
    output logic        out_illegal
);

    // Shared extender: keeps the low 'width' bits of raw and fills the upper
    // bits with either the field MSB (sign extend) or zero (zext=1, TRAP).
    function automatic logic [15:0] sext_field(
        input logic [15:0] raw,
        input logic [4:0]  width,
        input logic        zext
    );
        logic [15:0] res;
        logic        fill;
        fill = 1'b0;
        if (zext) begin
            fill = 1'b0;
        end else begin
            fill = raw[4'(width - 5'd1)];
        end
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < width) begin
                res[i] = raw[i];
            end else begin
                res[i] = fill;
            end
        end
        return res;
    endfunction

    logic [3:0]  opcode_s;
    logic [15:0] offset_s;
    logic [2:0]  nzp_s;
    logic        use_imm_s;
    logic        illegal_s;
    logic        accept_s;

    assign opcode_s = in_instr[15:12];
    assign in_ready = !out_valid || out_ready;
    // flush wins over both accept and consume, so it gates accept directly
    assign accept_s = in_valid && in_ready && !flush;

    // Opcode-dependent immediate selection and flag decode of the incoming word
    always_comb begin
        offset_s  = 16'h0000;
        nzp_s     = 3'b000;
        use_imm_s = 1'b0;
        illegal_s = 1'b0;
        case (opcode_s)
            4'b0001, 4'b0101: begin            // ADD, AND
                use_imm_s = in_instr[5];
                if (in_instr[5]) begin
                    offset_s = sext_field(in_instr, 5'd5, 1'b0);
                end else begin
                    offset_s = 16'h0000;
                end
            end
            4'b0000: begin                     // BR
                nzp_s    = in_instr[11:9];
                offset_s = sext_field(in_instr, 5'd9, 1'b0);
            end
            4'b0010, 4'b1010, 4'b1110,
            4'b0011, 4'b1011: begin            // LD, LDI, LEA, ST, STI
                offset_s = sext_field(in_instr, 5'd9, 1'b0);
            end
            4'b0110, 4'b0111: begin            // LDR, STR
                offset_s = sext_field(in_instr, 5'd6, 1'b0);
            end
            4'b0100: begin                     // JSR / JSRR (JSRR uses sr1)
                if (in_instr[11]) begin
                    offset_s = sext_field(in_instr, 5'd11, 1'b0);
                end else begin
                    offset_s = 16'h0000;
                end
            end
            4'b1111: begin                     // TRAP vector is unsigned
                offset_s = sext_field(in_instr, 5'd8, 1'b1);
            end
            4'b1000, 4'b1101: begin            // RTI, reserved
                illegal_s = 1'b1;
            end
            default: begin                     // NOT, JMP/RET: no immediate
                offset_s = 16'h0000;
            end
        endcase
    end

    // Pipeline slot: load on accept, drop on consume or flush, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= 4'h0;
            out_dr      <= 3'b000;
            out_sr1     <= 3'b000;
            out_sr2     <= 3'b000;
            out_nzp     <= 3'b000;
            out_use_imm <= 1'b0;
            out_offset  <= 16'h0000;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid   <= 1'b1;
            out_opcode  <= opcode_s;
            out_dr      <= in_instr[11:9];
            out_sr1     <= in_instr[8:6];
            out_sr2     <= in_instr[2:0];
            out_nzp     <= nzp_s;
            out_use_imm <= use_imm_s;
            out_offset  <= offset_s;
            out_illegal <= illegal_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_lc3_ir_decode.sv
// -----------------------------------------------------------------------------
// tb_lc3_ir_decode
// Self-checking bench for lc3_ir_decode: directed examples, backpressure,
// flush, reset during hold, then randomized traffic against a reference model
// that decodes with integer arithmetic and tracks slot occupancy.
// -----------------------------------------------------------------------------
module tb_lc3_ir_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_dr;
    logic [2:0]  out_sr1;
    logic [2:0]  out_sr2;
    logic [2:0]  out_nzp;
    logic        out_use_imm;
    logic [15:0] out_offset;
    logic        out_illegal;

    int checks_cnt;
    int errors_cnt;

    logic        exp_valid;
    logic [15:0] exp_instr;

    lc3_ir_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_dr      (out_dr),
        .out_sr1     (out_sr1),
        .out_sr2     (out_sr2),
        .out_nzp     (out_nzp),
        .out_use_imm (out_use_imm),
        .out_offset  (out_offset),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: signed value of the low w bits, wrapped into 16 bits
    function automatic logic [15:0] ref_signed(input int ins, input int w);
        int f;
        f = ins % (1 << w);
        if (f >= (1 << (w - 1))) f = f - (1 << w);
        return 16'((f + 65536) % 65536);
    endfunction

    function automatic logic [15:0] ref_offset(input logic [15:0] ins);
        int v;
        int op;
        v  = int'(ins);
        op = v / 4096;
        if (op == 1 || op == 5) return ((v / 32) % 2 == 1) ? ref_signed(v, 5) : 16'h0000;
        if (op == 0 || op == 2 || op == 10 || op == 14 || op == 3 || op == 11) return ref_signed(v, 9);
        if (op == 6 || op == 7) return ref_signed(v, 6);
        if (op == 4) return ((v / 2048) % 2 == 1) ? ref_signed(v, 11) : 16'h0000;
        if (op == 15) return 16'(v % 256);
        return 16'h0000;
    endfunction

    task automatic check_entry();
        int v;
        int op;
        v  = int'(exp_instr);
        op = v / 4096;
        check_val("opcode",  16'(out_opcode), 16'(op));
        check_val("dr",      16'(out_dr),     16'((v / 512) % 8));
        check_val("sr1",     16'(out_sr1),    16'((v / 64) % 8));
        check_val("sr2",     16'(out_sr2),    16'(v % 8));
        check_val("nzp",     16'(out_nzp),    (op == 0) ? 16'((v / 512) % 8) : 16'h0000);
        check_val("use_imm", 16'(out_use_imm),
                  ((op == 1 || op == 5) && (v / 32) % 2 == 1) ? 16'h0001 : 16'h0000);
        check_val("offset",  out_offset, ref_offset(exp_instr));
        check_val("illegal", 16'(out_illegal), (op == 8 || op == 13) ? 16'h0001 : 16'h0000);
    endtask

    // One clock with inputs already driven; entered and left on a falling edge
    task automatic tick();
        logic acc;
        #1;
        check_val("in_ready", 16'(in_ready), 16'(!exp_valid || out_ready));
        @(posedge clk);
        acc = in_valid && (!exp_valid || out_ready) && !flush;
        if (flush) exp_valid = 1'b0;
        else if (acc) begin
            exp_valid = 1'b1;
            exp_instr = in_instr;
        end
        else if (out_ready) exp_valid = 1'b0;
        #1;
        check_val("out_valid", 16'(out_valid), 16'(exp_valid));
        if (exp_valid) check_entry();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
    endtask

    logic [15:0] ex_instr [7];
    logic [15:0] ex_off   [7];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_valid  = 1'b0;
        exp_instr  = 16'h0000;
        rst_n      = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        ex_instr[0] = 16'h16FB; ex_off[0] = 16'hFFFB;
        ex_instr[1] = 16'h62A0; ex_off[1] = 16'hFFE0;
        ex_instr[2] = 16'h0EFF; ex_off[2] = 16'h00FF;
        ex_instr[3] = 16'hF0A5; ex_off[3] = 16'h00A5;
        ex_instr[4] = 16'h4C00; ex_off[4] = 16'hFC00;
        ex_instr[5] = 16'h4140; ex_off[5] = 16'h0000;
        ex_instr[6] = 16'h8000; ex_off[6] = 16'h0000;

        #12;
        check_val("rst_valid",  16'(out_valid), 16'h0000);
        check_val("rst_ready",  16'(in_ready),  16'h0001);
        check_val("rst_offset", out_offset,     16'h0000);
        check_val("rst_opcode", 16'(out_opcode), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Spec examples, streamed back to back
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ex_instr[i], 1'b1, 1'b0);
            tick();
            check_val("ex_offset", out_offset, ex_off[i]);
        end
        check_val("ex_illegal", 16'(out_illegal), 16'h0001);

        // Drain, then hold 0x16FB under backpressure
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h16FB, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h62A0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_offset", out_offset, 16'hFFFB);
        end
        drive(1'b1, 16'h62A0, 1'b1, 1'b0);
        tick();
        check_val("release_offset", out_offset, 16'hFFE0);

        // Back-to-back stream keeps out_valid high every cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'($urandom), 1'b1, 1'b0);
            tick();
            check_val("stream_valid", 16'(out_valid), 16'h0001);
        end

        // Flush drops both held entry and the presented instruction
        drive(1'b1, 16'h16FB, 1'b1, 1'b1);
        tick();
        check_val("flush_valid", 16'(out_valid), 16'h0000);

        // Reset asserted while an entry is held
        drive(1'b1, 16'h16FB, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_hold_valid",  16'(out_valid), 16'h0000);
        check_val("rst_hold_offset", out_offset,     16'h0000);
        check_val("rst_hold_ready",  16'(in_ready),  16'h0001);
        exp_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
